// File: rtl/sram_sched.sv
// sram_sched: time-slices one asynchronous 6-bit pixel SRAM port between the
// display read path and the pattern writer. Reads have priority. A saturating
// starvation counter forces a write once WR_STARVE reads have been granted
// while a write was waiting. A TURN cycle separates opposite-direction
// accesses, so the SRAM and this block never drive the data bus together.
module sram_sched #(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 6,
  parameter int WR_STARVE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_dq,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, RD_SETUP, RD_STROBE, WR_SETUP, WR_STROBE, WR_HOLD, TURN
  } state_e;

  localparam logic [7:0] STARVE_MAX = 8'(WR_STARVE);

  state_e            state_q, state_d;
  logic [7:0]        starve_q, starve_d;
  logic              turn_wr_q, turn_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              dq_oe_q, dq_oe_d;

  logic arb_point, wr_forced, grant_rd, grant_wr;

  // Arbitration: a starved write beats reads, otherwise reads beat writes.
  assign arb_point = (state_q == IDLE) || (state_q == RD_STROBE) || (state_q == WR_HOLD);
  assign wr_forced = wr_req && (starve_q == STARVE_MAX);
  assign grant_rd  = arb_point && rd_req && !wr_forced;
  assign grant_wr  = arb_point && wr_req && !grant_rd;

  // State register and all registered outputs; reset parks the bus safely.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      turn_wr_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      dq_oe_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      starve_q   <= starve_d;
      turn_wr_q  <= turn_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      dq_oe_q    <= dq_oe_d;
    end
  end

  // Next-state: direction changes detour through TURN, same direction chains.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned.
    state_d   = state_q;
    turn_wr_d = turn_wr_q;
    unique case (state_q)
      IDLE: begin
        if (grant_rd)      state_d = RD_SETUP;
        else if (grant_wr) state_d = WR_SETUP;
      end
      RD_SETUP:  state_d = RD_STROBE;
      RD_STROBE: begin
        if (grant_rd)      state_d = RD_SETUP;
        else if (grant_wr) state_d = TURN;
        else               state_d = IDLE;
      end
      WR_SETUP:  state_d = WR_STROBE;
      WR_STROBE: state_d = WR_HOLD;
      WR_HOLD: begin
        if (grant_wr)      state_d = WR_SETUP;
        else if (grant_rd) state_d = TURN;
        else               state_d = IDLE;
      end
      TURN:      state_d = turn_wr_q ? WR_SETUP : RD_SETUP;
      default:   state_d = IDLE;
    endcase
    if (grant_rd || grant_wr) turn_wr_d = grant_wr;
  end

  // Outputs: strobes decoded from the next state so they leave a flop cleanly.
  always_comb begin
    ce_n_d     = 1'b1;
    oe_n_d     = 1'b1;
    we_n_d     = 1'b1;
    dq_oe_d    = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rd_valid_d = 1'b0;
    unique case (state_d)
      RD_SETUP, RD_STROBE: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
      WR_SETUP, WR_HOLD: begin
        ce_n_d  = 1'b0;
        dq_oe_d = 1'b1;
      end
      WR_STROBE: begin
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        dq_oe_d = 1'b1;
      end
      default: ;
    endcase
    // Address and data are captured at the grant edge, even when TURN follows.
    if (grant_rd) begin
      addr_d = rd_addr;
    end else if (grant_wr) begin
      addr_d  = wr_addr;
      wdata_d = wr_data;
    end
    if (state_q == RD_STROBE) begin
      rdata_d    = sram_dq;
      rd_valid_d = 1'b1;
    end
  end

  // Starvation counter: counts reads granted over a waiting write, saturating.
  always_comb begin
    starve_d = starve_q;
    if (!wr_req || grant_wr)                     starve_d = '0;
    else if (grant_rd && starve_q != STARVE_MAX) starve_d = starve_q + 8'd1;
  end

  assign rd_ack    = (state_q == RD_SETUP);
  assign wr_ack    = (state_q == WR_SETUP);
  assign busy      = (state_q != IDLE);
  assign rd_data   = rdata_q;
  assign rd_valid  = rd_valid_q;
  assign sram_addr = addr_q;
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
  assign sram_dq   = dq_oe_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_sched.sv
// tb_sram_sched: bench for sram_sched with an asynchronous SRAM model,
// directed corner cases, a per-cycle vector table for a read/write/read
// sequence, and randomized requesters scored against a transaction model.
module tb_sram_sched;

  localparam int AW = 18;
  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_req, wr_req;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_ack, wr_ack, rd_valid, busy;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] sram_addr;
  logic          sram_ce_n, sram_oe_n, sram_we_n;
  wire  [DW-1:0] sram_dq;

  int n_checks = 0;
  int n_err    = 0;

  always #10 clk = ~clk;

  sram_sched dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .sram_addr(sram_addr), .sram_dq(sram_dq),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .busy(busy)
  );

  // Asynchronous SRAM model: drives dq while ce_n and oe_n are low.
  logic [DW-1:0] sram_mem [logic [AW-1:0]];
  logic [DW-1:0] exp_mem  [logic [AW-1:0]];
  logic [DW-1:0] sram_out = '0;

  function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : '0;
  endfunction

  assign sram_dq = (!sram_ce_n && !sram_oe_n) ? sram_out : {DW{1'bz}};

  always @(posedge clk) begin
    #1;
    sram_out = mem_read(sram_addr);
  end

  always @(negedge clk) begin
    if (rst && !sram_ce_n && !sram_we_n) sram_mem[sram_addr] = sram_dq;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] outs();
    return {sram_ce_n, sram_oe_n, sram_we_n, rd_ack, wr_ack, rd_valid, busy};
  endfunction

  // Bus monitor: read/write phases never abut; we_n pulse framed by stable addr/data.
  logic          mon_en = 1'b0;
  logic          prev_rd = 1'b0, prev_wr = 1'b0, prev_we_n = 1'b1;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_dq = '0;
  logic          now_rd, now_wr;

  always @(negedge clk) begin
    now_rd = !sram_ce_n && !sram_oe_n;
    now_wr = !sram_ce_n && sram_oe_n;
    if (mon_en) begin
      if (now_rd || now_wr)
        check("bus_phase", {29'd0, now_rd && prev_wr, now_wr && prev_rd, !sram_oe_n && !sram_we_n}, 0);
      if (!sram_we_n)
        check("we_setup", {28'd0, prev_wr, prev_we_n, prev_addr == sram_addr, prev_dq == sram_dq}, 32'hF);
      if (!prev_we_n)
        check("we_hold", {28'd0, now_wr, sram_we_n, prev_addr == sram_addr, prev_dq == sram_dq}, 32'hF);
    end
    prev_rd   = now_rd;
    prev_wr   = now_wr;
    prev_we_n = sram_we_n;
    prev_addr = sram_addr;
    prev_dq   = sram_dq;
  end

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] raddr;
    logic [6:0]    exp;    // {ce_n, oe_n, we_n, rd_ack, wr_ack, rd_valid, busy}
    logic [DW-1:0] exp_rd;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } rd_exp_t;

  vec_t    dir_vec [11];
  rd_exp_t rq [$];

  initial begin
    #(20 * 20000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rd_cnt1, rd_cnt2, wr_cyc1, wr_cyc2, first_rd2, rd_wait, wr_wait;
    logic [6:0] o;
    rd_exp_t e;

    // Read 0x200, write 0x201, read 0x201 back to back: TURN between each pair.
    dir_vec[0]  = '{1'b1, 1'b0, 18'h200, 7'b0011001, 6'h00};  // RD_SETUP
    dir_vec[1]  = '{1'b0, 1'b1, 18'h200, 7'b0010001, 6'h00};  // RD_STROBE
    dir_vec[2]  = '{1'b0, 1'b1, 18'h200, 7'b1110011, 6'h15};  // TURN, first rd_valid
    dir_vec[3]  = '{1'b0, 1'b1, 18'h200, 7'b0110101, 6'h00};  // WR_SETUP
    dir_vec[4]  = '{1'b1, 1'b0, 18'h201, 7'b0100001, 6'h00};  // WR_STROBE
    dir_vec[5]  = '{1'b1, 1'b0, 18'h201, 7'b0110001, 6'h00};  // WR_HOLD
    dir_vec[6]  = '{1'b1, 1'b0, 18'h201, 7'b1110001, 6'h00};  // TURN
    dir_vec[7]  = '{1'b1, 1'b0, 18'h201, 7'b0011001, 6'h00};  // RD_SETUP
    dir_vec[8]  = '{1'b0, 1'b0, 18'h201, 7'b0010001, 6'h00};  // RD_STROBE
    dir_vec[9]  = '{1'b0, 1'b0, 18'h201, 7'b1110010, 6'h2C};  // IDLE, final rd_valid
    dir_vec[10] = '{1'b0, 1'b0, 18'h201, 7'b1110000, 6'h00};  // IDLE

    rd_req = 0; wr_req = 0; rd_addr = '0; wr_addr = '0; wr_data = '0;

    // Reset held with random requests: everything parked.
    #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_outputs", {25'd0, outs()}, {25'd0, 7'b1110000});
      check("reset_addr_data", {8'd0, sram_addr, rd_data}, 0);
      rd_req  = 1'($urandom_range(0, 1));
      wr_req  = 1'($urandom_range(0, 1));
      rd_addr = 18'($urandom);
      wr_addr = 18'($urandom);
      wr_data = 6'($urandom);
    end
    @(negedge clk);
    rd_req = 0; wr_req = 0; rst = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {25'd0, outs()}, {25'd0, 7'b1110000});
    mon_en = 1'b1;

    // Single read of 0x00123.
    sram_mem[18'h00123] = 6'b101101;
    rd_addr = 18'h00123; rd_req = 1;
    @(negedge clk);
    check("rd1_c1_ack_oe_valid", {29'd0, rd_ack, sram_oe_n, rd_valid}, 3'b100);
    check("rd1_c1_addr", sram_addr, 18'h00123);
    rd_req = 0;
    @(negedge clk);
    check("rd1_c2_ack_oe_valid", {29'd0, rd_ack, sram_oe_n, rd_valid}, 3'b000);
    @(negedge clk);
    check("rd1_c3_ack_oe_valid", {29'd0, rd_ack, sram_oe_n, rd_valid}, 3'b011);
    check("rd1_data", rd_data, 6'b101101);

    // Single write of 0x0EA5F.
    @(negedge clk);
    wr_addr = 18'h0EA5F; wr_data = 6'b000011; wr_req = 1;
    @(negedge clk);
    check("wr1_c1_ack_we_oe", {29'd0, wr_ack, sram_we_n, sram_oe_n}, 3'b111);
    wr_req = 0;
    @(negedge clk);
    check("wr1_c2_ack_we_oe", {29'd0, wr_ack, sram_we_n, sram_oe_n}, 3'b001);
    check("wr1_c2_dq", sram_dq, 6'b000011);
    @(negedge clk);
    check("wr1_c3_ack_we_oe", {29'd0, wr_ack, sram_we_n, sram_oe_n}, 3'b011);
    @(negedge clk);
    check("wr1_readback", mem_read(18'h0EA5F), 6'b000011);

    // Direction change table, one row per clock edge.
    sram_mem[18'h200] = 6'h15;
    wr_addr = 18'h201; wr_data = 6'h2C;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rd_req = dir_vec[i].rd; wr_req = dir_vec[i].wr; rd_addr = dir_vec[i].raddr;
      @(posedge clk);
      #1;
      check($sformatf("dir_change[%0d]", i), {25'd0, outs()}, {25'd0, dir_vec[i].exp});
      if (dir_vec[i].exp[1]) check($sformatf("dir_data[%0d]", i), rd_data, dir_vec[i].exp_rd);
    end

    // Starvation: both requests held; cycle k is the cycle after grant edge k-1.
    @(negedge clk);
    rd_addr = 18'h300; wr_addr = 18'h301; wr_data = 6'h3A;
    rd_req = 1; wr_req = 1;
    rd_cnt1 = 0; rd_cnt2 = 0; wr_cyc1 = -1; wr_cyc2 = -1; first_rd2 = -1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      o = outs();
      if (rd_ack && wr_cyc1 < 0) rd_cnt1++;
      if (rd_ack && wr_cyc1 >= 0 && wr_cyc2 < 0) begin
        rd_cnt2++;
        if (first_rd2 < 0) first_rd2 = c;
      end
      if (wr_ack && wr_cyc1 < 0) wr_cyc1 = c;
      else if (wr_ack && wr_cyc2 < 0) wr_cyc2 = c;
      if (c == 17 || c == 21 || c == 38) check($sformatf("starve_turn_c%0d", c), {29'd0, o[6:4]}, 3'b111);
    end
    rd_req = 0; wr_req = 0;
    check("starve_reads_before_write", rd_cnt1, 8);
    check("starve_first_wr_ack_cycle", wr_cyc1, 18);
    check("starve_reads_resume_cycle", first_rd2, 22);
    check("starve_second_batch", rd_cnt2, 8);
    check("starve_second_wr_ack_cycle", wr_cyc2, 39);
    repeat (6) @(negedge clk);
    check("starve_idle", busy, 0);

    // Reset during WR_STROBE drops the write at once.
    mon_en = 1'b0;
    wr_addr = 18'h0400; wr_data = 6'h11; wr_req = 1;
    @(negedge clk);
    check("rstw_ack", wr_ack, 1);
    wr_req = 0;
    @(negedge clk);
    check("rstw_strobe_low", sram_we_n, 0);
    #2 rst = 1'b0;
    #1;
    check("rstw_async_strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    check("rstw_async_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rstw_after_release", {29'd0, wr_ack, busy, rd_valid}, 0);
    end
    mon_en = 1'b1;

    // Randomized requesters against a transaction-level memory model.
    for (int a = 0; a < 16; a++) begin
      sram_mem[18'h100 + 18'(a)] = 6'(a * 5 + 1);
      exp_mem[18'h100 + 18'(a)]  = 6'(a * 5 + 1);
    end
    rd_wait = 0; wr_wait = 0;
    for (int cyc = 0; cyc < 3100; cyc++) begin
      @(negedge clk);
      if (rd_ack) begin
        check("rnd_rd_ack_has_req", rd_req, 1);
        rq.push_back('{exp_mem[rd_addr], cyc});
        rd_req = 0;
      end
      if (wr_ack) begin
        check("rnd_wr_ack_has_req", wr_req, 1);
        exp_mem[wr_addr] = wr_data;
        wr_req = 0;
      end
      if (rd_valid) begin
        if (rq.size() == 0) begin
          check("rnd_unexpected_rd_valid", rd_valid, 0);
        end else begin
          e = rq.pop_front();
          check("rnd_rd_data", rd_data, e.data);
          check("rnd_rd_latency", cyc - e.cyc, 2);
        end
      end
      if (rd_req) begin
        rd_wait++;
        if (rd_wait > 40) begin
          check("rnd_rd_grant_timeout", rd_wait, 40);
          rd_req = 0;
        end
      end else if (cyc < 3000 && $urandom_range(0, 2) != 0) begin
        rd_req = 1; rd_addr = 18'h100 + 18'($urandom_range(0, 15)); rd_wait = 0;
      end
      if (wr_req) begin
        wr_wait++;
        if (wr_wait > 40) begin
          check("rnd_wr_grant_timeout", wr_wait, 40);
          wr_req = 0;
        end
      end else if (cyc < 3000 && $urandom_range(0, 1) != 0) begin
        wr_req = 1; wr_addr = 18'h100 + 18'($urandom_range(0, 15));
        wr_data = 6'($urandom); wr_wait = 0;
      end
    end
    check("rnd_drained", {30'd0, rd_req, wr_req}, 0);
    check("rnd_reads_outstanding", rq.size(), 0);
    check("rnd_idle", busy, 0);
    mon_en = 1'b0;
    for (int a = 0; a < 16; a++)
      check($sformatf("rnd_mem[%0d]", a), mem_read(18'h100 + 18'(a)), exp_mem[18'h100 + 18'(a)]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
